// File: rtl/slt32_seq.sv
// Multi-cycle SLT/SLTU unit: scans the operands MSB-first, STEP bits per cycle,
// and stops at the first chunk in which A and B differ.
module slt32_seq #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_unsigned,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] R
);
    localparam int NCHUNK = 32 / STEP;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_step_check
            $error("slt32_seq: STEP must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [31:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic          uns_q, uns_d;

    logic [4:0]      shamt;
    logic [31:0]     a_sh, b_sh;
    logic [STEP-1:0] ca, cb, diff;
    logic            hit, lt, accept;

    // Align chunk k to the top of the word; only the sign bit of chunk 0 is treated as signed.
    always_comb begin
        shamt = 5'(STEP * int'(k_q));
        a_sh  = a_q << shamt;
        b_sh  = b_q << shamt;
        ca    = a_sh[31 -: STEP];
        cb    = b_sh[31 -: STEP];
        diff  = ca ^ cb;
        hit   = |diff;
        lt    = 1'b0;
        for (int j = 0; j < STEP; j++) begin
            if (diff[j]) begin
                lt = (j == STEP - 1 && k_q == '0 && !uns_q) ? ca[j] : ~ca[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        r_d     = r_q;
        accept  = start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            IDLE: ;
            SCAN: begin
                if (hit || k_q == KW'(NCHUNK - 1)) begin
                    r_d     = {31'b0, lt};
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A request in DONE overrides the return to IDLE, giving back-to-back compares.
        if (accept) begin
            a_d     = A;
            b_d     = B;
            uns_d   = is_unsigned;
            k_d     = '0;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            r_q     <= r_d;
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign R    = r_q;

endmodule
